// File: rtl/hci_source_job_scheduler.sv
// hci_source_job_scheduler: queues {addr, len, stride} job descriptors and
// launches them one at a time on a source streamer, counting completions.
module hci_source_job_scheduler #(
   parameter int unsigned TRANS_CNT   = 16,
   parameter int unsigned QUEUE_DEPTH = 4,
   parameter int unsigned CNT_WIDTH   = 8
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clear_i,
   input  logic                           enable_i,
   input  logic                           job_valid_i,
   output logic                           job_ready_o,
   input  logic [31:0]                    job_addr_i,
   input  logic [TRANS_CNT-1:0]           job_len_i,
   input  logic [31:0]                    job_stride_i,
   output logic                           str_req_start_o,
   input  logic                           str_ready_start_i,
   input  logic                           str_done_i,
   output logic [31:0]                    str_addr_o,
   output logic [TRANS_CNT-1:0]           str_len_o,
   output logic [31:0]                    str_stride_o,
   output logic                           busy_o,
   output logic                           evt_o,
   output logic [CNT_WIDTH-1:0]           jobs_done_o,
   output logic [$clog2(QUEUE_DEPTH):0]   queue_level_o
);
   localparam int unsigned AW = $clog2(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, START, RUN} state_t;

   state_t                r_state, w_state_nxt;
   logic [31:0]           r_addr   [QUEUE_DEPTH];
   logic [TRANS_CNT-1:0]  r_len    [QUEUE_DEPTH];
   logic [31:0]           r_stride [QUEUE_DEPTH];
   logic [AW-1:0]         r_wptr, r_rptr;
   logic [AW:0]           r_level;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  w_en, w_empty, w_full, w_push, w_pop;

   // clear wins over everything, so it also masks this cycle's handshakes
   assign w_en    = enable_i & ~clear_i;
   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == (AW+1)'(QUEUE_DEPTH));
   assign w_push  = w_en & job_valid_i & ~w_full;

   assign job_ready_o   = ~w_full;
   assign str_addr_o    = w_empty ? '0 : r_addr[r_rptr];
   assign str_len_o     = w_empty ? '0 : r_len[r_rptr];
   assign str_stride_o  = w_empty ? '0 : r_stride[r_rptr];
   assign busy_o        = (r_state != IDLE) | ~w_empty;
   assign evt_o         = w_pop;
   assign jobs_done_o   = r_cnt;
   assign queue_level_o = r_level;

   always_comb begin
      w_state_nxt     = r_state;
      w_pop           = 1'b0;
      str_req_start_o = 1'b0;
      unique case (r_state)
         IDLE: if (w_en && !w_empty) begin
            // zero-length jobs complete here without touching the streamer
            if (str_len_o == '0) w_pop = 1'b1;
            else                 w_state_nxt = START;
         end
         START: if (w_en && str_ready_start_i) begin
            str_req_start_o = 1'b1;
            w_state_nxt     = RUN;
         end
         RUN: if (w_en && str_done_i) begin
            w_pop       = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_cnt   <= '0;
      end else if (clear_i) begin
         r_state <= IDLE;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_pop)  r_cnt  <= r_cnt + 1'b1;
         r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_addr[r_wptr]   <= job_addr_i;
         r_len[r_wptr]    <= job_len_i;
         r_stride[r_wptr] <= job_stride_i;
      end
   end
endmodule

// File: tb/tb_hci_source_job_scheduler.sv
// tb_hci_source_job_scheduler: directed scenarios plus a randomized run
// checked against a queue-based behavioural model.
module tb_hci_source_job_scheduler;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        clr = 1'b0, en = 1'b0, v = 1'b0, rdy = 1'b0, done = 1'b0;
   logic [31:0] addr = '0, stride = '0;
   logic [15:0] len = '0;
   logic        ready, req, busy, evt;
   logic [31:0] s_addr, s_stride;
   logic [15:0] s_len;
   logic [7:0]  cnt;
   logic [2:0]  level;
   int          checks = 0, errors = 0;

   hci_source_job_scheduler dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .enable_i(en),
      .job_valid_i(v), .job_ready_o(ready), .job_addr_i(addr), .job_len_i(len),
      .job_stride_i(stride), .str_req_start_o(req), .str_ready_start_i(rdy),
      .str_done_i(done), .str_addr_o(s_addr), .str_len_o(s_len),
      .str_stride_o(s_stride), .busy_o(busy), .evt_o(evt),
      .jobs_done_o(cnt), .queue_level_o(level)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks += 7;
      if (req !== 1'b0)    begin errors++; $display("FAIL rst_req got %b want 0", req); end
      if (evt !== 1'b0)    begin errors++; $display("FAIL rst_evt got %b want 0", evt); end
      if (busy !== 1'b0)   begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      if (level !== 3'd0)  begin errors++; $display("FAIL rst_level got %0d want 0", level); end
      if (s_addr !== 32'd0 || s_len !== 16'd0 || s_stride !== 32'd0)
         begin errors++; $display("FAIL rst_desc got %h/%h/%h want 0", s_addr, s_len, s_stride); end
      if (ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got %b want 1", ready); end
      if (cnt !== 8'd0)    begin errors++; $display("FAIL rst_cnt got %0d want 0", cnt); end
   endtask

   task automatic test_single_job();
      int nreq = 0, nevt = 0;
      cyc(); en = 1; rdy = 1; v = 1; addr = 32'h1000; len = 16; stride = 4; #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", ready); end
      cyc(); v = 0; #1;
      checks += 3;
      if (level !== 3'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
      if (s_addr !== 32'h1000 || s_len !== 16'd16 || s_stride !== 32'd4)
         begin errors++; $display("FAIL single_desc got %h/%0d/%0d want 1000/16/4", s_addr, s_len, s_stride); end
      if (req !== 1'b0) begin errors++; $display("FAIL single_req_idle got %b want 0", req); end
      cyc();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req_start got %b want 1", req); end
      nreq += int'(req);
      for (int i = 0; i < 19; i++) begin cyc(); nreq += int'(req); nevt += int'(evt); end
      cyc(); done = 1; #1;
      checks += 3;
      if (evt !== 1'b1) begin errors++; $display("FAIL single_evt got %b want 1", evt); end
      if (nreq != 1)    begin errors++; $display("FAIL single_req_count got %0d want 1", nreq); end
      if (nevt != 0)    begin errors++; $display("FAIL single_early_evt got %0d want 0", nevt); end
      cyc(); done = 0; #1;
      checks += 3;
      if (cnt !== 8'd1)  begin errors++; $display("FAIL single_cnt got %0d want 1", cnt); end
      if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b want 0", busy); end
      if (evt !== 1'b0)  begin errors++; $display("FAIL single_evt_len got %b want 0", evt); end
   endtask

   task automatic test_back_pressure();
      rdy = 0;
      for (int k = 0; k < 4; k++) begin
         cyc(); v = 1; addr = 32'h2000 + 32'(k) * 32'h100; len = 10; stride = 32'(k + 1);
      end
      cyc(); addr = 32'h3000; #1;
      checks += 2;
      if (level !== 3'd4) begin errors++; $display("FAIL bp_level got %0d want 4", level); end
      if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", ready); end
      for (int j = 0; j < 5; j++) begin
         checks += 3;
         if (req !== 1'b0)         begin errors++; $display("FAIL busy_req got %b want 0", req); end
         if (s_addr !== 32'h2000)  begin errors++; $display("FAIL busy_desc got %h want 2000", s_addr); end
         if (level !== 3'd4)       begin errors++; $display("FAIL bp_hold got %0d want 4", level); end
         cyc();
      end
      rdy = 1; #1;
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL busy_start got %b want 1", req); end
      cyc(); rdy = 0; done = 1; #1;
      checks += 2;
      if (evt !== 1'b1)   begin errors++; $display("FAIL bp_evt got %b want 1", evt); end
      if (ready !== 1'b0) begin errors++; $display("FAIL bp_ready_done got %b want 0", ready); end
      cyc(); done = 0; #1;
      checks += 3;
      if (ready !== 1'b1)       begin errors++; $display("FAIL bp_ready_after got %b want 1", ready); end
      if (level !== 3'd3)       begin errors++; $display("FAIL bp_level_after got %0d want 3", level); end
      if (s_addr !== 32'h2100)  begin errors++; $display("FAIL bp_head got %h want 2100", s_addr); end
      cyc(); v = 0; #1;
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL bp_fifth got %0d want 4", level); end
      clr = 1; cyc(); clr = 0; #1;
      checks += 2;
      if (level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL bp_clear level %0d busy %b want 0 0", level, busy); end
      if (cnt !== 8'd0) begin errors++; $display("FAIL bp_clear_cnt got %0d want 0", cnt); end
   endtask

   task automatic test_zero_len();
      rdy = 1;
      cyc(); v = 1; len = 0; addr = 32'h4000;
      cyc(); len = 8; addr = 32'h5000; #1;
      checks += 2;
      if (evt !== 1'b1) begin errors++; $display("FAIL zl_evt got %b want 1", evt); end
      if (req !== 1'b0) begin errors++; $display("FAIL zl_req got %b want 0", req); end
      cyc(); v = 0; #1;
      checks += 3;
      if (cnt !== 8'd1)         begin errors++; $display("FAIL zl_cnt1 got %0d want 1", cnt); end
      if (level !== 3'd1)       begin errors++; $display("FAIL zl_level got %0d want 1", level); end
      if (s_addr !== 32'h5000)  begin errors++; $display("FAIL zl_head got %h want 5000", s_addr); end
      cyc();
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL zl_start got %b want 1", req); end
      cyc(); done = 1; #1;
      checks++; if (evt !== 1'b1) begin errors++; $display("FAIL zl_evt2 got %b want 1", evt); end
      cyc(); done = 0; #1;
      checks += 2;
      if (cnt !== 8'd2)  begin errors++; $display("FAIL zl_cnt2 got %0d want 2", cnt); end
      if (busy !== 1'b0) begin errors++; $display("FAIL zl_busy got %b want 0", busy); end
   endtask

   task automatic test_wrap_clear();
      int pushes = 0, evts = 0;
      clr = 1; cyc(); clr = 0;
      for (int i = 0; i < 700 && evts < 256; i++) begin
         cyc(); v = (pushes < 256); len = 0; #1;
         evts += int'(evt);
         if (v && ready) pushes++;
      end
      cyc(); v = 0; #1;
      checks += 3;
      if (evts != 256)    begin errors++; $display("FAIL wrap_evts got %0d want 256", evts); end
      if (cnt !== 8'd0)   begin errors++; $display("FAIL wrap_cnt got %0d want 0", cnt); end
      if (level !== 3'd0) begin errors++; $display("FAIL wrap_level got %0d want 0", level); end
      rdy = 1;
      cyc(); v = 1; len = 5; addr = 32'h6000;
      cyc(); addr = 32'h6100;
      cyc(); addr = 32'h6200; #1;
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL clr_start got %b want 1", req); end
      cyc(); addr = 32'h6300;
      cyc(); v = 0; clr = 1; #1;
      checks++; if (level !== 3'd4) begin errors++; $display("FAIL clr_pre_level got %0d want 4", level); end
      cyc(); clr = 0; done = 1; #1;
      checks += 3;
      if (level !== 3'd0) begin errors++; $display("FAIL clr_level got %0d want 0", level); end
      if (busy !== 1'b0)  begin errors++; $display("FAIL clr_busy got %b want 0", busy); end
      if (evt !== 1'b0)   begin errors++; $display("FAIL clr_done_evt got %b want 0", evt); end
      cyc(); done = 0; #1;
      checks++; if (cnt !== 8'd0) begin errors++; $display("FAIL clr_cnt got %0d want 0", cnt); end
   endtask

   task automatic test_async_reset();
      rdy = 1;
      cyc(); v = 1; len = 0; addr = 32'h7000;
      cyc(); len = 5; addr = 32'h7100;
      cyc(); v = 0;
      cyc();
      cyc();
      checks += 2;
      if (cnt !== 8'd1)  begin errors++; $display("FAIL ar_pre_cnt got %0d want 1", cnt); end
      if (busy !== 1'b1) begin errors++; $display("FAIL ar_pre_busy got %b want 1", busy); end
      #2 rst_n = 0; #1;
      checks += 4;
      if (busy !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ar_busy_level got %b/%0d want 0/0", busy, level); end
      if (req !== 1'b0 || evt !== 1'b0)    begin errors++; $display("FAIL ar_req_evt got %b/%b want 0/0", req, evt); end
      if (s_addr !== 32'd0 || ready !== 1'b1) begin errors++; $display("FAIL ar_desc_ready got %h/%b want 0/1", s_addr, ready); end
      if (cnt !== 8'd0) begin errors++; $display("FAIL ar_cnt got %0d want 0", cnt); end
      @(negedge clk); rst_n = 1;
      cyc(); done = 1; #1;
      checks++; if (evt !== 1'b0) begin errors++; $display("FAIL ar_late_done got %b want 0", evt); end
      cyc(); done = 0;
   endtask

   typedef struct { logic [31:0] a; logic [15:0] l; logic [31:0] s; } job_t;

   task automatic test_random();
      job_t q[$];
      job_t h, nj;
      int   phase = 0;
      logic [7:0] m_cnt = 0;
      logic e_req, e_evt, e_busy, e_ready;
      for (int i = 0; i < 3000; i++) begin
         cyc();
         en     = ($urandom_range(0, 9) != 0);
         v      = 1'($urandom_range(0, 1));
         addr   = $urandom;
         len    = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
         stride = $urandom;
         rdy    = 1'($urandom_range(0, 1));
         done   = ($urandom_range(0, 3) == 0);
         clr    = ($urandom_range(0, 49) == 0);
         #1;
         h = q.size() > 0 ? q[0] : '{32'd0, 16'd0, 32'd0};
         e_ready = q.size() < 4;
         e_busy  = phase != 0 || q.size() > 0;
         e_req   = !clr && en && phase == 1 && rdy;
         e_evt   = !clr && en && ((phase == 0 && q.size() > 0 && h.l == 0) || (phase == 2 && done));
         checks += 9;
         if (level !== 3'(q.size())) begin errors++; $display("FAIL rnd_level @%0d got %0d want %0d", i, level, q.size()); end
         if (ready !== e_ready)      begin errors++; $display("FAIL rnd_ready @%0d got %b want %b", i, ready, e_ready); end
         if (busy !== e_busy)        begin errors++; $display("FAIL rnd_busy @%0d got %b want %b", i, busy, e_busy); end
         if (req !== e_req)          begin errors++; $display("FAIL rnd_req @%0d got %b want %b", i, req, e_req); end
         if (evt !== e_evt)          begin errors++; $display("FAIL rnd_evt @%0d got %b want %b", i, evt, e_evt); end
         if (cnt !== m_cnt)          begin errors++; $display("FAIL rnd_cnt @%0d got %0d want %0d", i, cnt, m_cnt); end
         if (s_addr !== h.a)         begin errors++; $display("FAIL rnd_addr @%0d got %h want %h", i, s_addr, h.a); end
         if (s_len !== h.l)          begin errors++; $display("FAIL rnd_len @%0d got %0d want %0d", i, s_len, h.l); end
         if (s_stride !== h.s)       begin errors++; $display("FAIL rnd_stride @%0d got %h want %h", i, s_stride, h.s); end
         if (clr) begin
            q.delete(); phase = 0; m_cnt = 0;
         end else if (en) begin
            nj = '{addr, len, stride};
            if (phase == 0 && q.size() > 0 && h.l != 0) phase = 1;
            else if (phase == 1 && rdy)                 phase = 2;
            else if (phase == 2 && done)                phase = 0;
            if (e_evt) begin void'(q.pop_front()); m_cnt++; end
            if (v && e_ready) q.push_back(nj);
         end
      end
      cyc(); clr = 0; en = 0; v = 0; done = 0;
   endtask

   initial begin
      #2 test_reset();
      @(negedge clk); rst_n = 1;
      test_single_job();
      test_back_pressure();
      test_zero_len();
      test_wrap_clear();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
